// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and
// the legal operand width range.
package serial_subtractor_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

    // One bit of full-subtractor output.
    typedef struct packed {
        logic d;
        logic bout;
    } sub_bit_t;

endpackage

// File: rtl/serial_subtractor_cell.sv
// One-bit subtraction cells: the half_subtractor primitive and a full
// subtractor composed from two of them.
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bout
);

    assign d    = a ^ b;
    assign bout = ~a & b;

endmodule

module full_subtractor
    import serial_subtractor_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic     d1;
    logic     b1;
    logic     b2;
    sub_bit_t res;

    half_subtractor u_hs0 (
        .a    (a),
        .b    (b),
        .d    (d1),
        .bout (b1)
    );

    half_subtractor u_hs1 (
        .a    (d1),
        .b    (bin),
        .d    (res.d),
        .bout (b2)
    );

    assign res.bout = b1 | b2;
    assign d        = res.d;
    assign bout     = res.bout;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b LSB first over WIDTH cycles
// with a start/done handshake and a registered result.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned          CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_subtractor: WIDTH must be in 2..32");
    end

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-2:0] res;
    logic [CNT_W-1:0] cnt;
    logic             bin;
    logic             d_bit;
    logic             bout_bit;

    full_subtractor u_cell (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (bin),
        .d    (d_bit),
        .bout (bout_bit)
    );

    assign busy = (state == S_SHIFT);
    assign done = (state == S_DONE);

    // The result register holds only the low WIDTH-1 bits; the final edge
    // appends the MSB straight from the cell when loading diff.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            sa         <= '0;
            sb         <= '0;
            res        <= '0;
            cnt        <= '0;
            bin        <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        res   <= '0;
                        cnt   <= '0;
                        bin   <= 1'b0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= (res >> 1) | ((WIDTH-1)'(d_bit) << (WIDTH - 2));
                    bin <= bout_bit;
                    if (cnt == CNT_LAST) begin
                        cnt        <= '0;
                        diff       <= {d_bit, res};
                        borrow_out <= bout_bit;
                        state      <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, scoreboard-checked bench for serial_subtractor at WIDTH=8 and an
// exhaustive sweep at WIDTH=4.
module tb_serial_subtractor;

    typedef struct packed {
        logic [7:0] d;
        logic       bo;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start4;
    logic [7:0] a8, b8, diff8;
    logic [3:0] a4, b4, diff4;
    logic       busy8, done8, bo8;
    logic       busy4, done4, bo4;

    exp_t q8[$];
    exp_t q4[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .start      (start8),
        .a          (a8),
        .b          (b8),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (bo8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start4),
        .a          (a4),
        .b          (b4),
        .busy       (busy4),
        .done       (done4),
        .diff       (diff4),
        .borrow_out (bo4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: wide subtraction, borrow is the extra top bit.
    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input int unsigned w);
        logic [8:0] full;
        exp_t       e;
        full = {1'b0, x} - {1'b0, y};
        e.d  = (w == 8) ? full[7:0] : (full[7:0] & 8'h0F);
        e.bo = full[8];
        return e;
    endfunction

    task automatic launch8(input logic [7:0] x, input logic [7:0] y, input bit push);
        start8 = 1'b1;
        a8     = x;
        b8     = y;
        if (push) q8.push_back(model(x, y, 8));
    endtask

    task automatic pop8(input string tag);
        exp_t e;
        check({tag, "_expected_done"}, 32'(q8.size() != 0), 1);
        if (q8.size() != 0) begin
            e = q8.pop_front();
            check({tag, "_diff"}, diff8, e.d);
            check({tag, "_borrow"}, bo8, e.bo);
        end
    endtask

    // Called on a negedge; returns on the negedge after the done cycle.
    task automatic op8(input string tag, input logic [7:0] x, input logic [7:0] y);
        int   cyc;
        int   bcyc;
        exp_t e;
        e = model(x, y, 8);
        launch8(x, y, 1);
        @(negedge clk);
        start8 = 1'b0;
        a8     = ~x;
        b8     = ~y;
        cyc    = 0;
        bcyc   = 0;
        while (!done8 && cyc < 20) begin
            if (busy8) bcyc++;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, 8);
        check({tag, "_busy_cycles"}, bcyc, 8);
        check({tag, "_busy_at_done"}, busy8, 0);
        pop8(tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, done8, 0);
        check({tag, "_hold"}, diff8, e.d);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int   ndone;
        int   tdone;
        int   cyc;
        int   tdn[3];
        exp_t e;

        rst    = 1'b1;
        start8 = 1'b0;
        start4 = 1'b0;
        a8     = '0;
        b8     = '0;
        a4     = '0;
        b4     = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy8, 0);
        check("reset_done", done8, 0);
        check("reset_diff", diff8, 0);
        check("reset_borrow", bo8, 0);
        check("reset_diff4", diff4, 0);
        rst = 1'b0;
        @(negedge clk);

        op8("t5a_23", 8'h5A, 8'h23);
        op8("t23_5a", 8'h23, 8'h5A);
        op8("t00_01", 8'h00, 8'h01);
        op8("tff_ff", 8'hFF, 8'hFF);

        // Second request during SHIFT must be ignored.
        launch8(8'h10, 8'h01, 1);
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ign_busy", busy8, 1);
        launch8(8'hAA, 8'h55, 0);
        @(negedge clk);
        start8 = 1'b0;
        ndone  = 0;
        tdone  = -1;
        for (int t = 3; t < 26; t++) begin
            if (done8) begin
                ndone++;
                if (tdone < 0) begin
                    tdone = t;
                    pop8("ign");
                end
            end
            @(negedge clk);
        end
        check("ign_done_count", ndone, 1);
        check("ign_done_time", tdone, 8);

        // Asynchronous reset during the 4th SHIFT cycle.
        launch8(8'h77, 8'h11, 0);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pre_busy", busy8, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_diff", diff8, 0);
        check("rst_borrow", bo8, 0);
        ndone = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        check("rst_no_done", ndone, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        op8("post_rst", 8'h09, 8'h04);

        // start held high: back-to-back operations.
        launch8(8'hC3, 8'h3C, 1);
        @(negedge clk);
        a8 = 8'h12;
        b8 = 8'h34;
        q8.push_back(model(8'h12, 8'h34, 8));
        ndone = 0;
        for (int t = 0; t < 40; t++) begin
            if (done8) begin
                if (ndone < 3) tdn[ndone] = t;
                ndone++;
                pop8("b2b");
            end
            if (t == 10) begin
                a8 = 8'h80;
                b8 = 8'h80;
                q8.push_back(model(8'h80, 8'h80, 8));
            end
            if (t == 20) start8 = 1'b0;
            @(negedge clk);
        end
        check("b2b_done_count", ndone, 3);
        check("b2b_done0", tdn[0], 8);
        check("b2b_done1", tdn[1], 18);
        check("b2b_done2", tdn[2], 28);

        // WIDTH=4 exhaustive sweep.
        for (int unsigned x = 0; x < 16; x++) begin
            for (int unsigned y = 0; y < 16; y++) begin
                start4 = 1'b1;
                a4     = 4'(x);
                b4     = 4'(y);
                q4.push_back(model(8'(x), 8'(y), 4));
                @(negedge clk);
                start4 = 1'b0;
                cyc    = 0;
                while (!done4 && cyc < 12) begin
                    @(negedge clk);
                    cyc++;
                end
                check($sformatf("w4_%0h_%0h_latency", x, y), cyc, 4);
                if (q4.size() != 0) begin
                    e = q4.pop_front();
                    check($sformatf("w4_%0h_%0h_diff", x, y), diff4, e.d);
                    check($sformatf("w4_%0h_%0h_borrow", x, y), bo4, e.bo);
                end
                @(negedge clk);
            end
        end

        $display("Teste completo");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
